tl_arbiter_rd: RTL and testbench
================================

# tl_arbiter_rd

Four-source read-side arbiter for the transaction layer: pops one word at a time from four upstream 10-bit FIFOs (virtual-channel/class queues) and writes it into a single downstream FIFO. Acts as the reader for the upstream FIFOs and the writer for the downstream FIFO. Honours the downstream almost-full flag so an issued pop is never lost. Sits between the per-class queues and the link-side FIFO.

## Interface
- DATA_W, 10, word width, equal to the FIFO data width
- RD_LAT, 2, cycles from a pop-high cycle to valid data on the source bus; legal 1..7

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- src_empty  in  4  per-source empty flag; bit n high = source n holds no word
- src_data0..src_data3  in  DATA_W each  read data buses of sources 0..3
- src_pop  out  4  one-hot pop strobe to source n, one cycle wide
- dst_almost_full  in  1  downstream FIFO almost-full
- dst_push  out  1  one-cycle push strobe to downstream FIFO
- dst_data  out  DATA_W  word to downstream FIFO, valid while dst_push high
- busy  out  1  high in every state except IDLE

## Operation
- Registered FSM: IDLE, POP, WAIT, CAP.
- IDLE: grant only when dst_almost_full=0 and at least one src_empty bit is 0. Winner chosen by the arbitration policy (see Configuration). On grant: latch winner index, next cycle src_pop[winner]=1, go POP.
- POP: src_pop[winner] high exactly this cycle. Load wait counter with RD_LAT-1. If RD_LAT=1 go directly to CAP, else go WAIT.
- WAIT: counter decrements each cycle; go CAP when counter reaches 1 (total WAIT cycles = RD_LAT-1).
- CAP: on the clock edge ending this cycle, dst_data <= src_data[winner], dst_push <= 1; go IDLE. Round-robin pointer updated to (winner+1) mod 4.
- dst_push is high for exactly one cycle (the first IDLE cycle after CAP); dst_data holds its value until the next capture.
- dst_almost_full and src_empty are sampled only in IDLE; changes in POP/WAIT/CAP are ignored. A granted transfer always completes with a push (downstream almost-full threshold guarantees headroom for one in-flight word).
- Never more than one src_pop bit high; never a pop to a source whose src_empty was 1 in the granting IDLE cycle.
- Counter is 3 bits; RD_LAT outside 1..7 is illegal.

## Timing
- Reset values: src_pop=0, dst_push=0, dst_data=0, busy=0, state IDLE, round-robin pointer 0, winner 0, counter 0.
- Grant evaluated in IDLE cycle t -> src_pop in cycle t+1 -> source data valid cycle t+1+RD_LAT-... sampled at end of cycle t+RD_LAT+1 -> dst_push in cycle t+RD_LAT+2.
- Back-to-back throughput: one word per RD_LAT+2 cycles; the dst_push cycle is an IDLE cycle and may grant again.
- Reset asserted mid-transfer: all state and outputs return to reset values immediately (asynchronous); an in-flight popped word is dropped, no push issued.
- All four sources empty or dst_almost_full=1: remain in IDLE, all strobes low, pointer unchanged.

## Configuration
- TL_ARB_STRICT_PRIO_EN defined: fixed priority, source 0 highest, source 3 lowest; round-robin pointer not used (held at 0).
- Not defined: round-robin; search starts at pointer and wraps 3->0; after a grant to n, pointer becomes (n+1) mod 4, so no non-empty source waits more than three grants.

## Test plan
- Reset then src_empty=4'b1110, src_data0=10'h155, RD_LAT=2 -> src_pop=4'b0001 one cycle, dst_push one cycle 3 cycles after pop with dst_data=10'h155, busy low again.
- All sources non-empty continuously, round-robin build -> pop order 0,1,2,3,0,...; one push every 4 cycles (RD_LAT=2).
- Same stimulus with TL_ARB_STRICT_PRIO_EN -> only source 0 popped while src_empty[0]=0; source 1 popped after src_empty[0] goes 1.
- dst_almost_full=1 in IDLE with non-empty sources -> no pop; raise dst_almost_full during WAIT after a grant -> transfer still completes with exactly one push.
- Assert reset during WAIT -> src_pop, dst_push, dst_data, busy all 0 at once; no push after reset release until a new grant.
- RD_LAT=1 and RD_LAT=7 builds -> push exactly RD_LAT+1 cycles after the pop cycle, data from the granted source.

Source files
------------

// File: rtl/tl_arbiter_rd.sv
// Four-source read arbiter: pops one word from an upstream FIFO and pushes it downstream.
// Optional build macro TL_ARB_STRICT_PRIO_EN selects fixed priority (source 0 highest) instead of round-robin.
module tl_arbiter_rd #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        src_empty,
    input  logic [DATA_W-1:0] src_data0,
    input  logic [DATA_W-1:0] src_data1,
    input  logic [DATA_W-1:0] src_data2,
    input  logic [DATA_W-1:0] src_data3,
    output logic [3:0]        src_pop,
    input  logic              dst_almost_full,
    output logic              dst_push,
    output logic [DATA_W-1:0] dst_data,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_CAP  = 2'd3;

    localparam logic [2:0] LAT_M1  = 3'(RD_LAT - 1);
    localparam bit         LAT_ONE = (RD_LAT == 1);

    logic [1:0]        state;
    logic [1:0]        winner;
    logic [1:0]        rr_ptr;
    logic [2:0]        cnt;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [1:0]        search_idx;
    logic [DATA_W-1:0] sel_data;

    // Search starts at the pointer and wraps 3->0; first non-empty source wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            search_idx = rr_ptr + 2'(i);
            if (!grant_valid && !src_empty[search_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = search_idx;
            end
        end
    end

    always_comb begin
        sel_data = src_data0;
        case (winner)
            2'd0:    sel_data = src_data0;
            2'd1:    sel_data = src_data1;
            2'd2:    sel_data = src_data2;
            default: sel_data = src_data3;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            winner   <= '0;
            cnt      <= '0;
            src_pop  <= '0;
            dst_push <= 1'b0;
            dst_data <= '0;
        end else begin
            src_pop  <= '0;
            dst_push <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!dst_almost_full && grant_valid) begin
                        winner  <= grant_idx;
                        src_pop <= 4'b0001 << grant_idx;
                        state   <= ST_POP;
                    end
                end
                ST_POP: begin
                    cnt   <= LAT_M1;
                    state <= LAT_ONE ? ST_CAP : ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= ST_CAP;
                end
                default: begin
                    dst_data <= sel_data;
                    dst_push <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TL_ARB_STRICT_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (state == ST_CAP)
            rr_ptr <= winner + 2'd1;
    end
`endif

    assign busy = (state != ST_IDLE);

    a_pop_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(src_pop));
    a_push_in_idle: assert property (@(posedge clk) disable iff (!reset) dst_push |-> (state == ST_IDLE));

endmodule

// File: tb/tb_tl_arbiter_rd.sv
// Directed bench for tl_arbiter_rd: main instance RD_LAT=2, plus RD_LAT=1 and RD_LAT=7 instances.
module tb_tl_arbiter_rd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] empty, empty_l1, empty_l7;
    logic [9:0] sd [4];
    logic       af;
    logic [3:0] pop, pop1, pop7;
    logic       push, push1, push7;
    logic [9:0] data, data1, data7;
    logic       busy, busy1, busy7;

    int n_cmp = 0;
    int n_err = 0;

    tl_arbiter_rd #(.DATA_W(10), .RD_LAT(2)) dut (
        .clk(clk), .reset(reset), .src_empty(empty),
        .src_data0(sd[0]), .src_data1(sd[1]), .src_data2(sd[2]), .src_data3(sd[3]),
        .src_pop(pop), .dst_almost_full(af), .dst_push(push), .dst_data(data), .busy(busy));

    tl_arbiter_rd #(.DATA_W(10), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .src_empty(empty_l1),
        .src_data0(sd[0]), .src_data1(sd[1]), .src_data2(sd[2]), .src_data3(sd[3]),
        .src_pop(pop1), .dst_almost_full(af), .dst_push(push1), .dst_data(data1), .busy(busy1));

    tl_arbiter_rd #(.DATA_W(10), .RD_LAT(7)) dut7 (
        .clk(clk), .reset(reset), .src_empty(empty_l7),
        .src_data0(sd[0]), .src_data1(sd[1]), .src_data2(sd[2]), .src_data3(sd[3]),
        .src_pop(pop7), .dst_almost_full(af), .dst_push(push7), .dst_data(data7), .busy(busy7));

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; af = 1'b0;
        empty = 4'b1111; empty_l1 = 4'b1111; empty_l7 = 4'b1111;
        sd[0] = 10'h155; sd[1] = 10'h0A6; sd[2] = 10'h2C3; sd[3] = 10'h3D4;
        @(negedge clk);
        n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL reset_pop: got %b want 0000", pop); end
        n_cmp++; if (push !== 1'b0) begin n_err++; $display("FAIL reset_push: got %b want 0", push); end
        n_cmp++; if (data !== 10'h000) begin n_err++; $display("FAIL reset_data: got %h want 000", data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({pop1, pop7, push1, push7, busy1, busy7} !== 12'h000) begin
            n_err++; $display("FAIL reset_lat_duts: got %h want 000", {pop1, pop7, push1, push7, busy1, busy7}); end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk) empty = 4'b1110;
        @(negedge clk);
        n_cmp++; if (pop !== 4'b0001) begin n_err++; $display("FAIL single_pop: got %b want 0001", pop); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
        empty = 4'b1111;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            n_cmp++; if ({pop, push} !== 5'b0) begin n_err++; $display("FAIL single_quiet%0d: got %b want 00000", k, {pop, push}); end
        end
        @(negedge clk);
        n_cmp++; if (push !== 1'b1) begin n_err++; $display("FAIL single_push: got %b want 1", push); end
        n_cmp++; if (data !== 10'h155) begin n_err++; $display("FAIL single_data: got %h want 155", data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (push !== 1'b0) begin n_err++; $display("FAIL single_push_once: got %b want 0", push); end
        n_cmp++; if (data !== 10'h155) begin n_err++; $display("FAIL single_hold: got %h want 155", data); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] emp [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0011};
`ifdef TL_ARB_STRICT_PRIO_EN
        int exp_src [8] = '{0, 0, 0, 0, 0, 1, 1, 2};
`else
        int exp_src [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        logic [3:0] exp_pop;
        do_reset();
        empty = emp[0];
        for (int g = 0; g < 8; g++) begin
            exp_pop = 4'(1 << exp_src[g]);
            @(negedge clk);
            n_cmp++; if (pop !== exp_pop) begin n_err++; $display("FAIL b2b_pop%0d: got %b want %b", g, pop, exp_pop); end
            for (int k = 1; k <= 2; k++) begin
                @(negedge clk);
                n_cmp++; if ({pop, push} !== 5'b0) begin n_err++; $display("FAIL b2b_gap%0d_%0d: got %b want 00000", g, k, {pop, push}); end
            end
            @(negedge clk);
            n_cmp++; if (push !== 1'b1) begin n_err++; $display("FAIL b2b_push%0d: got %b want 1", g, push); end
            n_cmp++; if (data !== sd[exp_src[g]]) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", g, data, sd[exp_src[g]]); end
            empty = (g < 7) ? emp[g + 1] : 4'b1111;
        end
        @(negedge clk);
        n_cmp++; if ({pop, push, busy} !== 6'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 000000", {pop, push, busy}); end
    endtask

    task automatic test_almost_full();
        do_reset();
        af = 1'b1; empty = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if ({pop, busy} !== 5'b0) begin n_err++; $display("FAIL af_block%0d: got %b want 00000", k, {pop, busy}); end
        end
        af = 1'b0;
        @(negedge clk);
        n_cmp++; if (pop !== 4'b0001) begin n_err++; $display("FAIL af_grant: got %b want 0001", pop); end
        @(negedge clk) af = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (push !== 1'b1) begin n_err++; $display("FAIL af_push: got %b want 1", push); end
        n_cmp++; if (data !== 10'h155) begin n_err++; $display("FAIL af_data: got %h want 155", data); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if ({pop, push} !== 5'b0) begin n_err++; $display("FAIL af_after%0d: got %b want 00000", k, {pop, push}); end
        end
        empty = 4'b1111; af = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        empty = 4'b1110;
        @(negedge clk) empty = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (data !== 10'h155) begin n_err++; $display("FAIL mid_pre_data: got %h want 155", data); end
        empty = 4'b1011;
        @(negedge clk);
        n_cmp++; if (pop !== 4'b0100) begin n_err++; $display("FAIL mid_pop: got %b want 0100", pop); end
        empty = 4'b1111;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({pop, push, busy} !== 6'b0) begin n_err++; $display("FAIL mid_async_ctl: got %b want 000000", {pop, push, busy}); end
        n_cmp++; if (data !== 10'h000) begin n_err++; $display("FAIL mid_async_data: got %h want 000", data); end
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++; if ({pop, push} !== 5'b0) begin n_err++; $display("FAIL mid_no_push%0d: got %b want 00000", k, {pop, push}); end
        end
        empty = 4'b1011;
        @(negedge clk);
        n_cmp++; if (pop !== 4'b0100) begin n_err++; $display("FAIL mid_regrant: got %b want 0100", pop); end
        empty = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (push !== 1'b1 || data !== 10'h2C3) begin n_err++; $display("FAIL mid_repush: got %b/%h want 1/2c3", push, data); end
    endtask

    task automatic test_lat1();
        @(negedge clk) empty_l1 = 4'b1101;
        @(negedge clk);
        n_cmp++; if (pop1 !== 4'b0010) begin n_err++; $display("FAIL lat1_pop: got %b want 0010", pop1); end
        empty_l1 = 4'b1111;
        @(negedge clk);
        n_cmp++; if (push1 !== 1'b0) begin n_err++; $display("FAIL lat1_early: got %b want 0", push1); end
        @(negedge clk);
        n_cmp++; if (push1 !== 1'b1 || data1 !== 10'h0A6) begin n_err++; $display("FAIL lat1_push: got %b/%h want 1/0a6", push1, data1); end
    endtask

    task automatic test_lat7();
        @(negedge clk) empty_l7 = 4'b0111;
        @(negedge clk);
        n_cmp++; if (pop7 !== 4'b1000) begin n_err++; $display("FAIL lat7_pop: got %b want 1000", pop7); end
        empty_l7 = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_cmp++; if (push7 !== 1'b0) begin n_err++; $display("FAIL lat7_early%0d: got %b want 0", k, push7); end
        end
        @(negedge clk);
        n_cmp++; if (push7 !== 1'b1 || data7 !== 10'h3D4) begin n_err++; $display("FAIL lat7_push: got %b/%h want 1/3d4", push7, data7); end
        @(negedge clk);
        n_cmp++; if (push7 !== 1'b0 || busy7 !== 1'b0) begin n_err++; $display("FAIL lat7_after: got %b/%b want 0/0", push7, busy7); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_almost_full();
        test_reset_mid();
        test_lat1();
        test_lat7();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish by 200000");
        $fatal(1);
    end

endmodule
